// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one LAT-cycle single-ported memory between fetch (I) and data (D) requesters.
// Define ARB_RR_EN to break I/D ties round-robin instead of fixed D priority.
module mem_port_arbiter #(
  parameter int LAT = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          stall_f,
  output logic          stall_m,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t state, stateNext;
  logic [3:0] cnt, cntNext;
  logic grantD, grantI, grant, done;
`ifdef ARB_RR_EN
  logic lastGrant;
  assign grantD = d_req & (~i_req | ~lastGrant);
  always_ff @(posedge clk or posedge rst)
    if (rst) lastGrant <= 1'b0;
    else if (state == IDLE && grant) lastGrant <= grantD;
`else
  assign grantD = d_req;
`endif
  assign grantI = i_req & ~grantD;
  assign grant = grantD | grantI;
  assign done = state != IDLE && cnt == 4'd0;
  assign stall_f = i_req & ~i_ready;
  assign stall_m = d_req & ~d_ready;
  always_comb begin
    stateNext = state;
    cntNext = cnt;
    if (state == IDLE) begin
      stateNext = grantD ? BUSY_D : grantI ? BUSY_I : IDLE;
      cntNext = grant ? 4'(LAT - 1) : 4'd0;
    end else if (done) stateNext = IDLE;
    else cntNext = cnt - 4'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
    end else begin
      state <= stateNext;
      cnt <= cntNext;
      i_ready <= done && state == BUSY_I;
      d_ready <= done && state == BUSY_D;
      if (state == IDLE && grant) begin
        mem_en <= 1'b1;
        mem_we <= grantD & d_we;
        mem_addr <= grantD ? d_addr : i_addr;
        if (grantD) mem_wdata <= d_wdata;
      end else if (done) begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
      end
      if (done && state == BUSY_I) i_rdata <= mem_rdata;
      // stores leave the last load result visible
      if (done && state == BUSY_D && !mem_we) d_rdata <= mem_rdata;
    end
  end
endmodule
